// File: rtl/tx_burst_fsm.sv
// tx_burst_fsm: burst transmitter over a valid/ready interface.
// A request in IDLE streams len_i words starting at seed_i, advancing by STEP
// per accepted word. Progress is reported through busy_o, sent_cnt_o and a
// one-cycle done_o pulse after the final word has been accepted.
module tx_burst_fsm #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  sent_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] STEP_W = DATA_W'(STEP);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic              xfer;
  logic [LEN_W:0]    next_idx_plus_one;
  logic              next_is_last;

  // A word moves only when it is being offered and the consumer takes it.
  assign xfer = valid_o & ready_i;

  // After this transfer the word on the bus has index sent_cnt_o+1; it is the
  // final one when sent_cnt_o+2 equals the burst length. One extra bit keeps
  // the sum from wrapping at the maximum burst length.
  assign next_idx_plus_one = {1'b0, sent_cnt_o} + (LEN_W+1)'(2);
  assign next_is_last      = (next_idx_plus_one == {1'b0, len_q});

  // Burst sequencer with every output registered; reset abandons any burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      len_q      <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      last_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      sent_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (tx_i && (len_i != '0)) begin
            len_q      <= len_i;
            data_o     <= seed_i;
            valid_o    <= 1'b1;
            busy_o     <= 1'b1;
            sent_cnt_o <= '0;
            last_o     <= (len_i == LEN_W'(1));
            state      <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last_o) begin
              valid_o    <= 1'b0;
              last_o     <= 1'b0;
              busy_o     <= 1'b0;
              sent_cnt_o <= len_q;
              done_o     <= 1'b1;
              state      <= DONE;
            end else begin
              data_o     <= data_o + STEP_W;
              sent_cnt_o <= sent_cnt_o + LEN_W'(1);
              last_o     <= next_is_last;
            end
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          valid_o <= 1'b0;
          last_o  <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_burst_fsm.sv
// tb_tx_burst_fsm: self-checking bench for tx_burst_fsm.
// Fixed vector table, hand-written corner sequences, a second instance with
// wider data and a larger step, and a randomized run against a queue model.
module tb_tx_burst_fsm;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int STEP   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_i;
  logic [3:0]  len_i;
  logic [7:0]  seed_i;
  logic        ready_i;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  sent_cnt_o;

  logic        tx6;
  logic [2:0]  len6;
  logic [15:0] seed6;
  logic        ready6;
  logic        valid6;
  logic [15:0] data6;
  logic        last6;
  logic        busy6;
  logic        done6;
  logic [2:0]  cnt6;

  int tests_run = 0;
  int tests_failed = 0;

  tx_burst_fsm #(.DATA_W(DATA_W), .LEN_W(LEN_W), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .tx_i(tx_i), .len_i(len_i), .seed_i(seed_i),
    .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o), .sent_cnt_o(sent_cnt_o)
  );

  tx_burst_fsm #(.DATA_W(16), .LEN_W(3), .STEP(3)) dut6 (
    .clk(clk), .rst(rst), .tx_i(tx6), .len_i(len6), .seed_i(seed6),
    .ready_i(ready6), .valid_o(valid6), .data_o(data6), .last_o(last6),
    .busy_o(busy6), .done_o(done6), .sent_cnt_o(cnt6)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Guard against a run that never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    string      name;
    logic       rst;
    logic       tx;
    logic [3:0] len;
    logic [7:0] seed;
    logic       ready;
    logic       v;
    logic       l;
    logic       b;
    logic       d;
    logic [3:0] cnt;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(string n, logic r, logic t, logic [3:0] ln,
                                 logic [7:0] s, logic rd, logic v, logic l,
                                 logic b, logic d, logic [3:0] c, logic [7:0] dt);
    vec_t x;
    x.name = n; x.rst = r; x.tx = t; x.len = ln; x.seed = s; x.ready = rd;
    x.v = v; x.l = l; x.b = b; x.d = d; x.cnt = c; x.data = dt;
    return x;
  endfunction

  // Drive the main instance's inputs, clock once, then settle away from the edge.
  task automatic applyStimulus(input logic r, input logic t, input logic [3:0] ln,
                               input logic [7:0] s, input logic rd);
    rst = r; tx_i = t; len_i = ln; seed_i = s; ready_i = rd;
    @(posedge clk);
    #1;
  endtask

  // One comparison of a packed observation against its expectation.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Compare the main instance's outputs; data only matters while valid.
  task automatic checkMain(input string name, input logic v, input logic l,
                           input logic b, input logic d, input logic [3:0] c,
                           input logic [7:0] dt);
    logic [7:0] act_data;
    logic [7:0] exp_data;
    act_data = v ? data_o : 8'h00;
    exp_data = v ? dt : 8'h00;
    checkOutput(name,
                {48'h0, valid_o, last_o, busy_o, done_o, sent_cnt_o, act_data},
                {48'h0, v, l, b, d, c, exp_data});
  endtask

  // Compare the wide-data instance's outputs.
  task automatic checkWide(input string name, input logic v, input logic l,
                           input logic b, input logic d, input logic [2:0] c,
                           input logic [15:0] dt);
    logic [15:0] act_data;
    logic [15:0] exp_data;
    act_data = v ? data6 : 16'h0;
    exp_data = v ? dt : 16'h0;
    checkOutput(name,
                {41'h0, valid6, last6, busy6, done6, cnt6, act_data},
                {41'h0, v, l, b, d, c, exp_data});
  endtask

  // Reference model: a burst is a queue of the words still to be accepted.
  logic [7:0] model_q[$];
  int         model_acc;
  bit         model_done;

  task automatic modelStep(input logic r, input logic t, input logic [3:0] ln,
                           input logic [7:0] s, input logic rd);
    if (!r) begin
      model_q.delete();
      model_acc  = 0;
      model_done = 0;
    end else if (model_done) begin
      model_done = 0;
    end else if (model_q.size() > 0) begin
      if (rd) begin
        void'(model_q.pop_front());
        model_acc++;
        if (model_q.size() == 0) model_done = 1;
      end
    end else if (t && ln != 0) begin
      model_acc = 0;
      for (int k = 0; k < int'(ln); k++) model_q.push_back(s + 8'(k * STEP));
    end
  endtask

  logic [15:0] exp6[7];

  initial begin
    rst = 1'b0; tx_i = 1'b0; len_i = '0; seed_i = '0; ready_i = 1'b0;
    tx6 = 1'b0; len6 = '0; seed6 = '0; ready6 = 1'b0;

    // Reset with a pending request, a full burst, a stalled wrapping burst,
    // a zero-length request and a single-word burst.
    vecs.push_back(mkVec("reset0",  0,1,4'd3,8'h10,1, 0,0,0,0,4'd0,8'h00));
    vecs.push_back(mkVec("reset1",  0,1,4'd3,8'h10,1, 0,0,0,0,4'd0,8'h00));
    vecs.push_back(mkVec("b3_start",1,1,4'd3,8'h10,1, 1,0,1,0,4'd0,8'h10));
    vecs.push_back(mkVec("b3_w1",   1,0,4'd0,8'h00,1, 1,0,1,0,4'd1,8'h11));
    vecs.push_back(mkVec("b3_w2",   1,0,4'd0,8'h00,1, 1,1,1,0,4'd2,8'h12));
    vecs.push_back(mkVec("b3_done", 1,0,4'd0,8'h00,1, 0,0,0,1,4'd3,8'h00));
    vecs.push_back(mkVec("b3_idle", 1,0,4'd0,8'h00,1, 0,0,0,0,4'd3,8'h00));
    vecs.push_back(mkVec("b4_start",1,1,4'd4,8'hFE,0, 1,0,1,0,4'd0,8'hFE));
    vecs.push_back(mkVec("b4_x1",   1,0,4'd0,8'h00,1, 1,0,1,0,4'd1,8'hFF));
    vecs.push_back(mkVec("b4_h1",   1,0,4'd0,8'h00,0, 1,0,1,0,4'd1,8'hFF));
    vecs.push_back(mkVec("b4_x2",   1,0,4'd0,8'h00,1, 1,0,1,0,4'd2,8'h00));
    vecs.push_back(mkVec("b4_h2",   1,0,4'd0,8'h00,0, 1,0,1,0,4'd2,8'h00));
    vecs.push_back(mkVec("b4_x3",   1,0,4'd0,8'h00,1, 1,1,1,0,4'd3,8'h01));
    vecs.push_back(mkVec("b4_h3",   1,0,4'd0,8'h00,0, 1,1,1,0,4'd3,8'h01));
    vecs.push_back(mkVec("b4_done", 1,0,4'd0,8'h00,1, 0,0,0,1,4'd4,8'h00));
    vecs.push_back(mkVec("done_tx", 1,1,4'd2,8'h55,1, 0,0,0,0,4'd4,8'h00));
    vecs.push_back(mkVec("len0",    1,1,4'd0,8'h77,1, 0,0,0,0,4'd4,8'h00));
    vecs.push_back(mkVec("len0_b",  1,0,4'd0,8'h00,1, 0,0,0,0,4'd4,8'h00));
    vecs.push_back(mkVec("b1_start",1,1,4'd1,8'hA5,1, 1,1,1,0,4'd0,8'hA5));
    vecs.push_back(mkVec("b1_done", 1,0,4'd0,8'h00,1, 0,0,0,1,4'd1,8'h00));
    vecs.push_back(mkVec("b1_idle", 1,0,4'd0,8'h00,1, 0,0,0,0,4'd1,8'h00));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].tx, vecs[i].len, vecs[i].seed, vecs[i].ready);
      checkMain(vecs[i].name, vecs[i].v, vecs[i].l, vecs[i].b, vecs[i].d,
                vecs[i].cnt, vecs[i].data);
    end

    // Mid-burst request with new len/seed must not disturb a 5-word burst.
    applyStimulus(1, 1, 4'd5, 8'h20, 1);  checkMain("b5_start", 1,0,1,0,4'd0,8'h20);
    applyStimulus(1, 0, 4'd0, 8'h00, 1);  checkMain("b5_w1",    1,0,1,0,4'd1,8'h21);
    applyStimulus(1, 0, 4'd0, 8'h00, 1);  checkMain("b5_w2",    1,0,1,0,4'd2,8'h22);
    applyStimulus(1, 1, 4'd2, 8'h99, 1);  checkMain("b5_txign", 1,0,1,0,4'd3,8'h23);
    applyStimulus(1, 0, 4'd0, 8'h00, 1);  checkMain("b5_w4",    1,1,1,0,4'd4,8'h24);
    applyStimulus(1, 0, 4'd0, 8'h00, 1);  checkMain("b5_done",  0,0,0,1,4'd5,8'h00);
    applyStimulus(1, 0, 4'd0, 8'h00, 1);  checkMain("b5_idle",  0,0,0,0,4'd5,8'h00);

    // Reset in the middle of a burst: abandoned, no done pulse afterwards.
    applyStimulus(1, 1, 4'd5, 8'h40, 1);  checkMain("r_start",  1,0,1,0,4'd0,8'h40);
    applyStimulus(1, 0, 4'd0, 8'h00, 1);  checkMain("r_w1",     1,0,1,0,4'd1,8'h41);
    applyStimulus(0, 0, 4'd0, 8'h00, 1);  checkMain("r_reset",  0,0,0,0,4'd0,8'h00);
    applyStimulus(1, 0, 4'd0, 8'h00, 1);  checkMain("r_nodone", 0,0,0,0,4'd0,8'h00);

    // Wide instance: 7 words, step 3, wrapping through zero.
    exp6 = '{16'hFFFA, 16'hFFFD, 16'h0000, 16'h0003, 16'h0006, 16'h0009, 16'h000C};
    tx6 = 1'b1; len6 = 3'd7; seed6 = 16'hFFFA; ready6 = 1'b1;
    applyStimulus(1, 0, 4'd0, 8'h00, 0);
    tx6 = 1'b0; len6 = 3'd0; seed6 = 16'h0;
    for (int k = 0; k < 7; k++) begin
      checkWide($sformatf("w_word%0d", k), 1, (k == 6), 1, 0, 3'(k), exp6[k]);
      applyStimulus(1, 0, 4'd0, 8'h00, 0);
    end
    checkWide("w_done", 0, 0, 0, 1, 3'd7, 16'h0);
    applyStimulus(1, 0, 4'd0, 8'h00, 0);
    checkWide("w_idle", 0, 0, 0, 0, 3'd7, 16'h0);
    ready6 = 1'b0;

    // Randomized traffic against the queue model, starting from reset.
    modelStep(0, 0, 4'd0, 8'h00, 0);
    applyStimulus(0, 0, 4'd0, 8'h00, 0);
    for (int i = 0; i < 600; i++) begin
      logic       r, t, rd;
      logic [3:0] ln;
      logic [7:0] s;
      r  = ($urandom_range(0, 59) != 0);
      t  = ($urandom_range(0, 2) == 0);
      ln = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      s  = 8'($urandom);
      rd = ($urandom_range(0, 9) < 7);
      modelStep(r, t, ln, s, rd);
      applyStimulus(r, t, ln, s, rd);
      checkMain($sformatf("rand%0d", i),
                model_q.size() > 0,
                model_q.size() == 1,
                model_q.size() > 0,
                model_done,
                4'(model_acc),
                (model_q.size() > 0) ? model_q[0] : 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
